// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 8N1 serial receiver with a 2-flop input synchroniser and a one-byte valid/ready holding register.
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rs232_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t state, nxt;
   logic s1, rx_s;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bitcnt;
   logic [DATA_BITS-1:0] shreg;
   logic half, full, deliver, bad_stop;
   assign busy = state != IDLE;
   always_comb begin
      half = cnt == HALF;
      full = cnt == FULL;
      deliver = state == STOP && full && rx_s;
      bad_stop = state == STOP && full && !rx_s;
      nxt = state;
      case (state)
         IDLE:    nxt = rx_s ? IDLE : START;
         START:   nxt = half ? (rx_s ? IDLE : DATA) : START;
         DATA:    nxt = full && bitcnt == LAST ? STOP : DATA;
         STOP:    nxt = full ? (rx_s ? IDLE : BRK) : STOP;
         BRK:     nxt = rx_s ? IDLE : BRK;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         bitcnt <= '0;
         shreg <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         s1 <= rs232_rx;
         rx_s <= s1;
         state <= nxt;
         cnt <= (nxt != state || full) ? '0 : cnt + CW'(1);
         bitcnt <= state == DATA ? (full ? bitcnt + BW'(1) : bitcnt) : '0;
         if (state == DATA && full) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         frame_err <= bad_stop;
         // a delivery into a full register that is not being drained drops the new byte
         overrun <= deliver && rx_valid && !rx_ready;
         rx_valid <= deliver || (rx_valid && !rx_ready);
         if (deliver && (!rx_valid || rx_ready)) rx_data <= shreg;
      end
   end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: drives 8N1 frames on the serial line and checks delivered bytes, flags and timing
// against a queue of expected bytes built from what was sent.
module tb_uart_rx_deserializer;
   localparam int CPB = 16;
   localparam int DB = 8;
   logic clk = 1'b0, reset, rs232_rx, rx_ready;
   logic [DB-1:0] rx_data;
   logic rx_valid, frame_err, overrun, busy;
   int total = 0, bad = 0, cyc = 0, fall_cyc = 0, rise_cyc = 0;
   int vcyc, fe_n, ov_n, both;
   logic busy_seen, pv = 1'b0;
   logic [7:0] got_q[$], exp_q[$];

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk(clk), .reset(reset), .rs232_rx(rs232_rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid && rx_ready) got_q.push_back(rx_data);
         if (rx_valid) vcyc++;
         if (rx_valid && !pv) rise_cyc = cyc;
         if (frame_err) fe_n++;
         if (overrun) ov_n++;
         if (frame_err && overrun) both++;
         if (busy) busy_seen = 1'b1;
      end
      pv = rx_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      got_q.delete();
      exp_q.delete();
      vcyc = 0;
      fe_n = 0;
      ov_n = 0;
      both = 0;
      busy_seen = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic stp, input int stop_bits);
      rs232_rx = 1'b0;
      fall_cyc = cyc;
      tick(CPB);
      for (int i = 0; i < DB; i++) begin
         rs232_rx = d[i];
         tick(CPB);
      end
      rs232_rx = stp;
      tick(CPB * stop_bits);
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   initial begin
      int n;
      logic [7:0] b;
      reset = 1'b1;
      rs232_rx = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      chk("rst_data", rx_data, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      tick(2);

      // single frame, consumer always ready
      clr();
      rx_ready = 1'b1;
      exp_q.push_back(8'hC5);
      send(8'hC5, 1'b1, 1);
      tick(4);
      cmp_q("t1");
      chk("t1_valid_cycles", vcyc, 1);
      chk("t1_ferr", fe_n, 0);
      chk("t1_busy_seen", busy_seen, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_latency", rise_cyc - fall_cyc, CPB / 2 + (DB + 1) * CPB + 3);

      // consumer stalled: second byte overruns, first stays held
      clr();
      rx_ready = 1'b0;
      send(8'h55, 1'b1, 1);
      tick(2);
      send(8'hAA, 1'b1, 1);
      tick(4);
      chk("t2_valid_held", rx_valid, 1);
      chk("t2_data_held", rx_data, 8'h55);
      chk("t2_overrun_cycles", ov_n, 1);
      chk("t2_none_taken", got_q.size(), 0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
      exp_q.push_back(8'h55);
      cmp_q("t2");
      chk("t2_valid_after", rx_valid, 0);
      chk("t2_data_after", rx_data, 8'h55);

      // short low glitch is rejected silently
      clr();
      rx_ready = 1'b1;
      rs232_rx = 1'b0;
      tick(CPB / 4);
      rs232_rx = 1'b1;
      n = 0;
      while (busy && n < CPB / 2 + 3) begin
         tick(1);
         n++;
      end
      chk("t3_busy_end", busy, 0);
      chk("t3_busy_seen", busy_seen, 1);
      chk("t3_valid_cycles", vcyc, 0);
      chk("t3_ferr", fe_n, 0);

      // bad stop bit, line stuck low, then recovery
      clr();
      send(8'h3C, 1'b0, 3);
      chk("t4_busy_in_break", busy, 1);
      chk("t4_ferr_cycles", fe_n, 1);
      chk("t4_valid_cycles", vcyc, 0);
      rs232_rx = 1'b1;
      tick(4);
      chk("t4_busy_release", busy, 0);
      send(8'h81, 1'b1, 1);
      tick(3);
      exp_q.push_back(8'h81);
      cmp_q("t4");
      chk("t4_ferr_total", fe_n, 1);

      // random bytes with random idle gaps
      clr();
      for (int k = 0; k < 20; k++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send(b, 1'b1, 1);
         tick($urandom_range(0, 2 * CPB));
      end
      tick(3);
      cmp_q("rnd");
      chk("rnd_ferr", fe_n, 0);
      chk("rnd_ovr", ov_n, 0);
      chk("rnd_both", both, 0);

      // back-to-back frames with no idle time
      clr();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send(8'h00, 1'b1, 1);
      send(8'hFF, 1'b1, 1);
      tick(3);
      cmp_q("t5");
      chk("t5_ferr", fe_n, 0);
      chk("t5_ovr", ov_n, 0);

      // reset in the middle of bit 4
      clr();
      b = 8'hA5;
      rs232_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rs232_rx = b[i];
         tick(CPB);
      end
      rs232_rx = b[4];
      tick(CPB / 2);
      chk("t6_busy_before", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_data", rx_data, 0);
      chk("t6_rst_valid", rx_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ferr", frame_err, 0);
      chk("t6_rst_ovr", overrun, 0);
      rs232_rx = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
      clr();
      exp_q.push_back(8'h12);
      send(8'h12, 1'b1, 1);
      tick(3);
      cmp_q("t6");
      chk("t6_ferr", fe_n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
